masked_sbox_collector: RTL and testbench

- Downstream stage of the two-share masked AES S-box pipeline (step1 -> step2 ANF gadgets).
- Tracks which of the non-stallable S-box pipeline slots carry real bytes, then captures the 8-bit two-share outputs into a 16-byte two-share SubBytes state.
- Presents the full state to the MixColumns/ShiftRows stage with a valid/ready handshake.
- Shares stay in separate registers end to end and are never combined.

---
 rtl/masked_sbox_collector_pkg.sv | 30 +++
 rtl/masked_sbox_collector_if.sv | 51 +++++
 rtl/masked_sbox_collector_valid_pipe.sv | 46 ++++
 rtl/masked_sbox_collector.sv | 168 ++++++++++++++++
 tb/tb_masked_sbox_collector.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/masked_sbox_collector_pkg.sv
// ---------------------------------------------------------------------------
// masked_aes_pkg
//   Shared constants and types for the two-share masked AES datapath.
//   - SHARE_W / NUM_BYTES : share width and bytes per AES state
//   - SBOX_LATENCY_*      : issue-to-output latency of the masked S-box for
//                           the pipelined and non-pipelined gadget builds
//   - coll_state_t        : collector FSM encoding
//   - count_width()       : width of a counter that must reach n inclusive
// ---------------------------------------------------------------------------
package masked_aes_pkg;

  localparam int SHARE_W   = 8;
  localparam int NUM_BYTES = 16;

  // step1 -> step2 ANF gadgets, each split into register stages
  localparam int SBOX_LATENCY_PIPELINED   = 4;
  // step1 -> step2 ANF gadgets, one register stage each
  localparam int SBOX_LATENCY_UNPIPELINED = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } coll_state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/masked_sbox_collector_if.sv
// ---------------------------------------------------------------------------
// masked_sbox_collector_if
//   Bundles the issue handshake, the two S-box result shares and the
//   collected-state handshake of the masked S-box collector.
//   Signals:
//     in_valid  / in_ready   : byte issue into the non-stallable S-box pipe
//     sbox_out0 / sbox_out1  : S-box result shares (LATENCY after issue)
//     state0    / state1     : collected two-share SubBytes state
//     out_valid / out_ready  : state handoff to MixColumns/ShiftRows
//   Modports:
//     master : upstream issuer + S-box pipe + downstream consumer side
//     slave  : the collector
// ---------------------------------------------------------------------------
interface masked_sbox_collector_if
  import masked_aes_pkg::*;
#(
  parameter int NUM_BYTES = masked_aes_pkg::NUM_BYTES
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [SHARE_W-1:0]             sbox_out0;
  logic [SHARE_W-1:0]             sbox_out1;
  logic [SHARE_W*NUM_BYTES-1:0]   state0;
  logic [SHARE_W*NUM_BYTES-1:0]   state1;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output in_valid,
    output sbox_out0,
    output sbox_out1,
    output out_ready,
    input  in_ready,
    input  state0,
    input  state1,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  sbox_out0,
    input  sbox_out1,
    input  out_ready,
    output in_ready,
    output state0,
    output state1,
    output out_valid
  );

endinterface

// File: rtl/masked_sbox_collector_valid_pipe.sv
// ---------------------------------------------------------------------------
// sbox_valid_pipe
//   Valid-tag shift register running alongside a non-stallable S-box
//   pipeline. A tag entering on `in` appears on `out` LATENCY cycles later.
//   Reset clears every tag, so bytes in flight at reset are never claimed.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     in    : accepted-issue flag
//     out   : result valid flag (LATENCY cycles later)
//   Parameter LATENCY: legal range 1..8.
// ---------------------------------------------------------------------------
module sbox_valid_pipe #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  logic [LATENCY-1:0] pipe_reg;

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pipe_reg <= '0;
        end else begin
          pipe_reg <= in;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pipe_reg <= '0;
        end else begin
          pipe_reg <= {pipe_reg[LATENCY-2:0], in};
        end
      end
    end
  endgenerate

  assign out = pipe_reg[LATENCY-1];

endmodule

// File: rtl/masked_sbox_collector.sv
// ---------------------------------------------------------------------------
// masked_sbox_collector
//   Downstream stage of the two-share masked AES S-box. Tracks which slots
//   of the non-stallable S-box pipeline carry real bytes, captures each
//   two-share result into its byte position and hands the complete
//   16-byte two-share state to the next round stage. The two shares live in
//   separate registers throughout and are never combined.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : masked_sbox_collector_if.slave (issue handshake, S-box
//             shares, collected state, output handshake)
//
//   Parameters:
//     LATENCY   : issue-to-sbox_out latency, 1..8
//     NUM_BYTES : bytes per collected state
//
//   Build option:
//     SHARE_REG_CLEAR_EN : when defined, the share registers are zeroed on
//       the handoff edge so every new byte overwrites zero instead of the
//       previous state's share (no cross-state transition leakage).
//       Consumers must not sample state0/state1 after the handoff.
// ---------------------------------------------------------------------------
module masked_sbox_collector
  import masked_aes_pkg::*;
#(
  parameter int LATENCY   = SBOX_LATENCY_PIPELINED,
  parameter int NUM_BYTES = masked_aes_pkg::NUM_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  masked_sbox_collector_if.slave   bus
);

  localparam int CW = count_width(NUM_BYTES);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_DONE    = DONE;

  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BYTES - 1);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] issue_cnt_reg, issue_cnt_next;
  logic [CW-1:0] cap_cnt_reg, cap_cnt_next;

  logic in_ready;
  logic issue_acc;
  logic cap_en;
  logic cap_write;
  logic handoff;

  // The S-box pipe never stalls, so acceptance depends only on local state.
  assign in_ready  = (state_reg != ST_DONE) && (issue_cnt_reg < CNT_FULL);
  assign issue_acc = bus.in_valid && in_ready;
  assign handoff   = (state_reg == ST_DONE) && bus.out_ready;
  // DONE freezes the state even if a stray tag were to arrive.
  assign cap_write = cap_en && (state_reg != ST_DONE);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_reg == ST_DONE);

  sbox_valid_pipe #(
    .LATENCY (LATENCY)
  ) u_valid_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (issue_acc),
    .out   (cap_en)
  );

  // -------------------------------------------------------------------------
  // FSM and counters
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (issue_acc) begin
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Last byte lands this edge: cap_cnt becomes NUM_BYTES.
        if (cap_write && (cap_cnt_reg == CNT_LAST)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    issue_cnt_next = issue_cnt_reg;
    cap_cnt_next   = cap_cnt_reg;
    if (handoff) begin
      issue_cnt_next = '0;
      cap_cnt_next   = '0;
    end else begin
      if (issue_acc) begin
        issue_cnt_next = issue_cnt_reg + CW'(1);
      end
      if (cap_write) begin
        cap_cnt_next = cap_cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      issue_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= issue_cnt_next;
      cap_cnt_reg   <= cap_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Share registers: one byte per share per position, written only when the
  // capture pointer addresses that position.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      logic [SHARE_W-1:0] share0_reg;
      logic [SHARE_W-1:0] share1_reg;
      logic               sel;

      assign sel = cap_write && (cap_cnt_reg == CW'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          share0_reg <= '0;
          share1_reg <= '0;
`ifdef SHARE_REG_CLEAR_EN
        end else if (handoff) begin
          share0_reg <= '0;
          share1_reg <= '0;
`endif
        end else if (sel) begin
          share0_reg <= bus.sbox_out0;
          share1_reg <= bus.sbox_out1;
        end
      end

      assign bus.state0[SHARE_W*gi +: SHARE_W] = share0_reg;
      assign bus.state1[SHARE_W*gi +: SHARE_W] = share1_reg;
    end
  endgenerate

  // Issue count is capped at NUM_BYTES, so every tag lands before DONE.
  a_no_capture_in_done : assert property (
    @(posedge clk) disable iff (!rst_n) !(cap_en && (state_reg == ST_DONE))
  );

endmodule

// File: tb/tb_masked_sbox_collector.sv
module tb_masked_sbox_collector;
  import masked_aes_pkg::*;

  localparam int LAT = 4;
  localparam int NB  = 16;

  typedef struct {
    logic [8*NB-1:0] s0;
    logic [8*NB-1:0] s1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_sbox_collector_if #(.NUM_BYTES(NB)) bus ();

  masked_sbox_collector #(
    .LATENCY   (LAT),
    .NUM_BYTES (NB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  // ---------------- S-box pipeline stand-in (non-stallable, no reset) -----
  logic [7:0]     pend0 = 8'h00;
  logic [7:0]     pend1 = 8'h00;
  logic [LAT-1:0] tvalid = '0;
  logic [7:0]     td0 [LAT];
  logic [7:0]     td1 [LAT];
  int             cyc = 0;
  int             last_issue = 0;
  int             acc_cnt = 0;

  always @(posedge clk) begin
    tvalid <= {tvalid[LAT-2:0], (rst_n && bus.in_valid && bus.in_ready)};
    td0[0] <= pend0;
    td1[0] <= pend1;
    for (int i = 1; i < LAT; i++) begin
      td0[i] <= td0[i-1];
      td1[i] <= td1[i-1];
    end
    if (rst_n && bus.in_valid && bus.in_ready) begin
      acc_cnt    <= acc_cnt + 1;
      last_issue <= cyc;
    end
    cyc <= cyc + 1;
  end

  // Off-slot data is junk so a capture in the wrong cycle corrupts the state.
  assign bus.sbox_out0 = tvalid[LAT-1] ? td0[LAT-1] : 8'hEE;
  assign bus.sbox_out1 = tvalid[LAT-1] ? td1[LAT-1] : 8'h11;

  task automatic chk(input string name, input logic [8*NB-1:0] act,
                     input logic [8*NB-1:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic exp_t build_exp(input logic [7:0] base, input logic [7:0] mask);
    exp_t e;
    for (int k = 0; k < NB; k++) begin
      e.s0[8*k +: 8] = base ^ 8'(k);
      e.s1[8*k +: 8] = mask ^ 8'(k);
    end
    return e;
  endfunction

  // ---------------- monitor: compare on each new out_valid ----------------
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_out: got out_valid=1 required no output");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_state0", bus.state0, e.s0);
        chk("out_state1", bus.state1, e.s1);
        chk("out_latency", 128'(cyc - last_issue), 128'(LAT + 1));
      end
    end
    prev_ov = rst_n && bus.out_valid;
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic issue_run(input logic [7:0] base, input logic [7:0] mask,
                           input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      pend0 = base ^ 8'(k);
      pend1 = mask ^ 8'(k);
      chk("issue_ready", 128'(bus.in_ready), 128'(1));
      @(posedge clk);
      if (gap && (k != n - 1)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
      end
    end
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    while (!bus.out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL out_timeout: got out_valid=0 required 1 within 200 cycles");
    end
  endtask

  // Called at the negedge following the handoff edge.
  task automatic chk_after_handoff(input exp_t prev);
    chk("handoff_ov", 128'(bus.out_valid), 128'(0));
    chk("handoff_ready", 128'(bus.in_ready), 128'(1));
`ifdef SHARE_REG_CLEAR_EN
    chk("handoff_state0", bus.state0, '0);
    chk("handoff_state1", bus.state1, '0);
`else
    chk("handoff_state0", bus.state0, prev.s0);
    chk("handoff_state1", bus.state1, prev.s1);
`endif
  endtask

  task automatic full_run(input logic [7:0] base, input logic [7:0] mask,
                          input bit gap);
    last_exp = build_exp(base, mask);
    exp_q.push_back(last_exp);
    issue_run(base, mask, NB, gap);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ready_drop", 128'(bus.in_ready), 128'(0));
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    int saved_acc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_ov", 128'(bus.out_valid), 128'(0));
    chk("rst_state0", bus.state0, '0);
    chk("rst_state1", bus.state1, '0);
    rst_n = 1'b1;

    // back-to-back fill, out_ready high -> one-cycle pulse
    full_run(8'h63, 8'h00, 1'b0);
    wait_out();
    @(negedge clk);
    chk_after_handoff(last_exp);

    // alternate-cycle issue, shares re-masked (xor still 0x63)
    full_run(8'hC6, 8'hA5, 1'b1);
    wait_out();
    @(negedge clk);
    chk_after_handoff(last_exp);

    // backpressure with in_valid held
    bus.out_ready = 1'b0;
    last_exp = build_exp(8'h7C, 8'h5A);
    exp_q.push_back(last_exp);
    issue_run(8'h7C, 8'h5A, NB, 1'b0);
    @(negedge clk);
    chk("bp_ready_drop", 128'(bus.in_ready), 128'(0));
    wait_out();
    saved_acc = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ov", 128'(bus.out_valid), 128'(1));
      chk("bp_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_state0", bus.state0, last_exp.s0);
      chk("bp_state1", bus.state1, last_exp.s1);
    end
    chk("bp_no_issue", 128'(acc_cnt), 128'(saved_acc));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_after_handoff(last_exp);

    // reset with 7 bytes captured and 3 in flight
    issue_run(8'h11, 8'h22, 10, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_state0", bus.state0, '0);
    chk("mrst_state1", bus.state1, '0);
    chk("mrst_ready", 128'(bus.in_ready), 128'(1));
    chk("mrst_ov", 128'(bus.out_valid), 128'(0));
    rst_n = 1'b1;
    full_run(8'h36, 8'h55, 1'b0);
    wait_out();
    @(negedge clk);
    chk_after_handoff(last_exp);

    repeat (5) @(negedge clk);
    chk("queue_drain", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
